// File: rtl/lcd_reader.sv
// lcd_reader: read-side engine for an HD44780-compatible LCD in 4-bit mode.
// Clocks one byte out of the panel as two nibbles (high first), either the
// busy flag + address counter (RS=0) or a data byte (RS=1). Poll mode
// repeats BF reads until the panel is ready or MAX_POLLS reads are spent.
// Ports:
//   CLK, RST_N            clock, async active-low reset
//   rd_start/rd_rs        request pulse and register select (accepted when !busy)
//   poll_busy             1 = poll BF until clear (RS forced to 0)
//   LCD_D_IN[3:0]         panel D7..D4 (input only; this block never drives D)
//   rd_data/rd_valid      byte read and its one-cycle completion strobe
//   timeout               with rd_valid: poll exhausted, BF still set
//   busy/owns_bus         request in progress; top muxes E/RS/RW on owns_bus
//   LCD_E/LCD_RS/LCD_RW   panel strobes (all registered)
module lcd_reader #(
  parameter int T_AS      = 3,
  parameter int T_PW      = 25,
  parameter int T_EL      = 25,
  parameter int T_AH      = 4,
  parameter int MAX_POLLS = 1000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       rd_start,
  input  logic       rd_rs,
  input  logic       poll_busy,
  input  logic [3:0] LCD_D_IN,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       timeout,
  output logic       busy,
  output logic       owns_bus,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW
);

  typedef enum logic [2:0] {IDLE, SETUP, E1_HI, E1_LO, E2_HI, E2_LO, DONE} state_t;

  // Timer is loaded with (duration-1) on state entry and exits at zero.
  localparam logic [15:0] TM_AS = 16'(T_AS - 1);
  localparam logic [15:0] TM_PW = 16'(T_PW - 1);
  localparam logic [15:0] TM_EL = 16'(T_EL - 1);
  localparam logic [15:0] TM_AH = 16'(T_AH - 1);
  localparam logic [16:0] MAXP  = 17'(MAX_POLLS);

  state_t      state;
  logic [15:0] tmr;
  logic [15:0] poll_cnt;
  logic [15:0] poll_inc;
  logic        poll_q;
  logic [7:0]  shadow;

  assign owns_bus = busy;
  assign poll_inc = (poll_cnt == 16'hFFFF) ? poll_cnt : poll_cnt + 16'd1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      tmr      <= '0;
      poll_cnt <= '0;
      poll_q   <= 1'b0;
      shadow   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      timeout  <= 1'b0;
      busy     <= 1'b0;
      LCD_E    <= 1'b0;
      LCD_RS   <= 1'b0;
      LCD_RW   <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        IDLE: if (rd_start) begin
          LCD_RS   <= poll_busy ? 1'b0 : rd_rs;
          LCD_RW   <= 1'b1;
          busy     <= 1'b1;
          poll_q   <= poll_busy;
          poll_cnt <= '0;
          timeout  <= 1'b0;
          tmr      <= TM_AS;
          state    <= SETUP;
        end
        SETUP: if (tmr == '0) begin
          LCD_E <= 1'b1;
          tmr   <= TM_PW;
          state <= E1_HI;
        end else tmr <= tmr - 16'd1;
        // Panel data is stable before E falls; sample on the last high cycle.
        E1_HI: if (tmr == '0) begin
          LCD_E       <= 1'b0;
          shadow[7:4] <= LCD_D_IN;
          tmr         <= TM_EL;
          state       <= E1_LO;
        end else tmr <= tmr - 16'd1;
        E1_LO: if (tmr == '0) begin
          LCD_E <= 1'b1;
          tmr   <= TM_PW;
          state <= E2_HI;
        end else tmr <= tmr - 16'd1;
        E2_HI: if (tmr == '0) begin
          LCD_E       <= 1'b0;
          shadow[3:0] <= LCD_D_IN;
          tmr         <= TM_AH;
          state       <= E2_LO;
        end else tmr <= tmr - 16'd1;
        E2_LO: if (tmr == '0) begin
          if (poll_q) poll_cnt <= poll_inc;
          if (poll_q && shadow[7] && ({1'b0, poll_inc} < MAXP)) begin
            // Re-poll with RS/RW untouched; no completion strobe.
            tmr   <= TM_AS;
            state <= SETUP;
          end else begin
            // Result registered here so rd_valid is high during DONE.
            rd_data  <= shadow;
            rd_valid <= 1'b1;
            timeout  <= poll_q & shadow[7];
            state    <= DONE;
          end
        end else tmr <= tmr - 16'd1;
        DONE: begin
          LCD_RW <= 1'b0;
          LCD_RS <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_reader.sv
// Directed bench for lcd_reader: a panel model feeds nibbles on each E rise,
// expected {timeout,rd_data} words are queued at request time and popped
// when rd_valid appears; latency, E pulse count/width and RS/RW stability
// are checked per transaction.
module tb_lcd_reader;
  localparam int T_PW = 25;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       rd_start = 1'b0, rd_rs = 1'b0, poll_busy = 1'b0;
  logic [3:0] LCD_D_IN = 4'h0;
  logic [7:0] rd_data;
  logic       rd_valid, timeout, busy, owns_bus, LCD_E, LCD_RS, LCD_RW;

  int checks = 0;
  int errors = 0;
  logic [8:0] sb[$];   // {timeout, rd_data}
  logic [3:0] pnl[$];  // nibbles the panel presents on successive E pulses

  lcd_reader #(.MAX_POLLS(5)) dut (
    .CLK(CLK), .RST_N(RST_N), .rd_start(rd_start), .rd_rs(rd_rs),
    .poll_busy(poll_busy), .LCD_D_IN(LCD_D_IN), .rd_data(rd_data),
    .rd_valid(rd_valid), .timeout(timeout), .busy(busy), .owns_bus(owns_bus),
    .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW));

  always #5 CLK = ~CLK;

  always @(posedge LCD_E) LCD_D_IN = (pnl.size() > 0) ? pnl.pop_front() : 4'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request; inputs are changed right after acceptance to show
  // they are not sampled again.
  task automatic start(input bit rs, input bit poll, input bit exp_rs,
                       input logic [8:0] exp, input bit push);
    @(negedge CLK);
    rd_rs = rs; poll_busy = poll; rd_start = 1'b1;
    if (push) sb.push_back(exp);
    @(negedge CLK);
    rd_start = 1'b0; rd_rs = ~rs; poll_busy = ~poll;
    chk("accept busy", busy, 1);
    chk("accept owns_bus", owns_bus, 1);
    chk("accept RW", LCD_RW, 1);
    chk("accept RS", LCD_RS, exp_rs);
    chk("accept timeout cleared", timeout, 0);
  endtask

  task automatic count_valid(input string tag, input int ncyc);
    int n = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge CLK);
      if (rd_valid) n++;
    end
    chk(tag, n, 0);
  endtask

  // Follow a transaction to rd_valid; collide_at > 0 pulses rd_start then.
  task automatic run(input string tag, input bit exp_rs, input int exp_lat,
                     input int exp_pulses, input int collide_at);
    int cyc = 0, pulses = 0, hi = 0, bad_hi = 0, bad_bus = 0;
    bit got = 0, prev_e = 0;
    logic [8:0] e;
    while (!got && cyc < 3000) begin
      @(negedge CLK);
      cyc++;
      rd_start = (collide_at > 0 && cyc == collide_at);
      if (LCD_E) begin
        if (!prev_e) pulses++;
        hi++;
      end else begin
        if (prev_e && hi != T_PW) bad_hi++;
        hi = 0;
      end
      prev_e = LCD_E;
      if (busy && (LCD_RS !== exp_rs || LCD_RW !== 1'b1)) bad_bus++;
      if (rd_valid) got = 1;
    end
    rd_start = 1'b0;
    chk({tag, " rd_valid seen"}, got, 1);
    e = (sb.size() > 0) ? sb.pop_front() : 9'h1FF;
    chk({tag, " rd_data"}, rd_data, e[7:0]);
    chk({tag, " timeout"}, timeout, e[8]);
    chk({tag, " latency"}, cyc, exp_lat);
    chk({tag, " E pulses"}, pulses, exp_pulses);
    chk({tag, " E width"}, bad_hi, 0);
    chk({tag, " RS/RW stable"}, bad_bus, 0);
    chk({tag, " busy in DONE"}, busy, 1);
    @(negedge CLK);
    chk({tag, " rd_valid one cycle"}, rd_valid, 0);
    chk({tag, " busy released"}, busy, 0);
    chk({tag, " RW released"}, LCD_RW, 0);
    chk({tag, " RS released"}, LCD_RS, 0);
    chk({tag, " timeout held"}, timeout, e[8]);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst rd_data", rd_data, 0);
    chk("rst rd_valid", rd_valid, 0);
    chk("rst timeout", timeout, 0);
    chk("rst busy", busy, 0);
    chk("rst owns_bus", owns_bus, 0);
    chk("rst E", LCD_E, 0);
    chk("rst RS", LCD_RS, 0);
    chk("rst RW", LCD_RW, 0);
    @(negedge CLK); RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    // Data read
    pnl = '{4'h4, 4'h8};
    start(1, 0, 1, 9'h048, 1);
    run("data", 1, 82, 2, 0);

    // BF/address read
    pnl = '{4'h2, 4'h5};
    start(0, 0, 0, 9'h025, 1);
    run("bf", 0, 82, 2, 0);

    // Poll success after three busy reads; rd_rs must be ignored
    pnl = '{4'h8, 4'h0, 4'h8, 4'h0, 4'h8, 4'h0, 4'h0, 4'h7};
    start(1, 1, 0, 9'h007, 1);
    run("poll ok", 0, 328, 8, 0);

    // Poll timeout at MAX_POLLS=5
    pnl = '{4'h8, 4'h0, 4'h8, 4'h0, 4'h8, 4'h0, 4'h8, 4'h0, 4'h8, 4'h0};
    start(0, 1, 0, 9'h180, 1);
    run("poll to", 0, 410, 10, 0);
    repeat (5) @(negedge CLK);
    chk("timeout holds while idle", timeout, 1);

    // Collision: rd_start mid-read is dropped (start() checks timeout clears)
    pnl = '{4'h3, 4'hC};
    start(0, 0, 0, 9'h03C, 1);
    run("collide", 0, 82, 2, 40);
    count_valid("collide no extra rd_valid", 150);

    // Reset during E2_HI (cycles 53..77 after acceptance)
    pnl = '{4'hF, 4'hE};
    start(1, 0, 1, 9'h000, 0);
    repeat (59) @(negedge CLK);
    chk("pre-reset E high", LCD_E, 1);
    RST_N = 1'b0;
    #1;
    chk("mid rst E", LCD_E, 0);
    chk("mid rst busy", busy, 0);
    chk("mid rst owns_bus", owns_bus, 0);
    chk("mid rst RW", LCD_RW, 0);
    chk("mid rst RS", LCD_RS, 0);
    chk("mid rst rd_data", rd_data, 0);
    chk("mid rst rd_valid", rd_valid, 0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    pnl.delete();
    count_valid("after rst no rd_valid", 120);

    // Fresh request after reset
    pnl = '{4'hA, 4'h5};
    start(1, 0, 1, 9'h0A5, 1);
    run("post rst", 1, 82, 2, 0);

    chk("scoreboard empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lcd_reader.md
# lcd_reader

Read-side engine for the HD44780-compatible character LCD in 4-bit mode. It drives RS/RW/E to clock a byte out of the panel as two nibbles: either the busy flag plus address counter, or a DDRAM/CGRAM data byte. An optional poll mode repeats busy-flag reads until the panel is ready. It sits beside the existing LCD writer/init engine; the top level uses `owns_bus` to select which engine drives LCD_E/LCD_RS/LCD_RW.

## Interface

Parameters:
- `T_AS`, 3: address-setup cycles, RS/RW valid to E rise (≥1).
- `T_PW`, 25: E-high cycles per nibble (≥2; 25 at 50 MHz = 500 ns).
- `T_EL`, 25: E-low cycles between nibbles (≥1).
- `T_AH`, 4: hold cycles after second E fall before release or re-poll (≥1).
- `MAX_POLLS`, 1000: maximum busy-flag reads in poll mode (1..65535).

Ports (clock and reset first):
- `CLK` input 1: system clock; all state changes on rising edge.
- `RST_N` input 1: reset, asynchronous and active-low.
- `rd_start` input 1: single-cycle request; accepted only while `busy`=0.
- `rd_rs` input 1: register select for the request (0 = BF/address, 1 = data); ignored when `poll_busy`=1.
- `poll_busy` input 1: 1 = poll mode, with RS forced to 0.
- `LCD_D_IN` input 4: panel D7..D4 as seen by the FPGA.
- `rd_data` output 8: last byte read; high nibble first.
- `rd_valid` output 1: one-cycle pulse when `rd_data` is updated and the request completes.
- `timeout` output 1: valid with `rd_valid`; 1 = poll exhausted with BF still 1.
- `busy` output 1: request in progress.
- `owns_bus` output 1: equal to `busy`; top muxes LCD_E/LCD_RS/LCD_RW from this block.
- `LCD_E` output 1: enable strobe.
- `LCD_RS` output 1: register select.
- `LCD_RW` output 1: 1 = read.

## Operation

- This block never drives LCD_D; data only flows in.
- Reset values: `rd_data`=0, `rd_valid`=0, `timeout`=0, `busy`=0, `LCD_E`=0, `LCD_RS`=0, `LCD_RW`=0, poll count=0.
- States: IDLE → SETUP → E1_HI → E1_LO → E2_HI → E2_LO → DONE → IDLE.
- IDLE
  - `rd_start`=1 latches RS: `poll_busy` ? 0 : `rd_rs`.
  - Sets `LCD_RW`=1 and `busy`=1, clears poll count, then goes to SETUP.
- SETUP: T_AS cycles with E=0, then E1_HI.
- E1_HI
  - T_PW cycles with E=1.
  - On the edge leaving this state, `LCD_D_IN` is captured into a shadow high nibble.
- E1_LO: T_EL cycles with E=0.
- E2_HI: T_PW cycles with E=1; on exit the low nibble is captured.
- E2_LO: T_AH cycles with E=0. On exit:
  - Not in poll mode: go to DONE.
  - Poll mode: increment poll count (16-bit, saturating).
  - Poll mode, BF (shadow bit 7)=1 and count < MAX_POLLS: re-enter SETUP; RS/RW held, `rd_valid` not pulsed.
  - Otherwise: go to DONE.
- DONE (1 cycle)
  - `rd_data` ← shadow, `rd_valid`=1.
  - `timeout` = poll mode AND BF=1.
  - `LCD_RW`←0, `LCD_RS`←0, `busy`←0 on the next edge, then IDLE.
- `rd_start` while `busy`=1 is ignored, not queued. `rd_rs`/`poll_busy` changes after acceptance have no effect.
- `timeout` holds its value until the next accepted request, which clears it.
- `RST_N` low mid-operation: E drops immediately (asynchronously), all outputs go to their reset values, FSM returns to IDLE, and no `rd_valid` is produced.

## Timing

- Latency for a single read, from the accepting edge to the `rd_valid`-high cycle: T_AS + 2·T_PW + T_EL + T_AH cycles.
  - Defaults: 3+50+25+4 = 82.
- Each additional poll iteration adds the same 82 cycles.
- E rises exactly T_AS cycles after RW/RS become valid. RS/RW stay stable from acceptance through DONE.
- Data is sampled combinationally on the last E-high cycle. The panel guarantees data valid ≥ tDDR before E falls; no synchronizer is used.
- `rd_valid` is high for exactly one cycle. `busy` falls on the cycle after `rd_valid`.
- Back-to-back: a new `rd_start` can be accepted at the earliest the cycle after `busy`=0.

## Test plan

- Data read: `rd_start` with `rd_rs`=1, panel model drives 0x4 then 0x8.
  - Required: `rd_data`=0x48 and `rd_valid` 82 cycles after acceptance.
  - Required: E high twice for 25 cycles each; RS=1, RW=1 throughout.
- BF read: `rd_rs`=0, panel returns 0x2 then 0x5.
  - Required: `rd_data`=0x25, `timeout`=0, LCD_RS=0.
- Poll success: `poll_busy`=1, BF=1 for 3 reads, then the panel returns 0x0/0x7.
  - Required: a single `rd_valid` at 4·82 cycles, `rd_data`=0x07, `timeout`=0, 8 E pulses in total.
- Poll timeout: MAX_POLLS=5, BF held at 1 (panel drives 0x8/0x0).
  - Required: `rd_valid` after 5·82 cycles, `rd_data`=0x80, `timeout`=1.
- Collision and reset
  - `rd_start` pulsed mid-read: ignored, with exactly one `rd_valid`.
  - `RST_N` low during E2_HI: E=0 at once, `busy`=0, no `rd_valid`; a fresh request afterwards completes normally.
